// File: rtl/ct_ciu_ctcq_pkg.sv
// Shared definitions for the CTC/DVM request queue scheduler.
package ct_ciu_ctcq_pkg;

  // Target indices, matching the entry aim bit order.
  localparam int unsigned TGT_NUM  = 6;
  localparam int unsigned TGT_PIU0 = 0;
  localparam int unsigned TGT_PIU1 = 1;
  localparam int unsigned TGT_PIU2 = 2;
  localparam int unsigned TGT_PIU3 = 3;
  localparam int unsigned TGT_EBIU = 4;
  localparam int unsigned TGT_L2C  = 5;

  // Flat per-target entry vectors are entry-major within each target.
  function automatic int unsigned tgt_vec_idx(input int unsigned tgt,
                                              input int unsigned entry,
                                              input int unsigned entry_num);
    return tgt * entry_num + entry;
  endfunction

endpackage

// File: rtl/ct_ciu_ctcq_reqq_sched_if.sv
// Request queue scheduler bus: allocation, entry status, target handshakes
// and response-done routing. master = scheduler, slave = entries/targets.
interface ct_ciu_ctcq_reqq_sched_if #(
  parameter int unsigned ENTRY_NUM = 8,
  parameter int unsigned ENTRY_W   = 3
);
  import ct_ciu_ctcq_pkg::*;

  // Allocation
  logic                          ctc_dvm_vld;
  logic                          ctc_dvm_grant;
  logic [ENTRY_NUM-1:0]          reqq_create_en;
  logic                          reqq_full;

  // Entry status fed back from the entry array
  logic [ENTRY_NUM-1:0]          reqq_vld;
  logic [TGT_NUM*ENTRY_NUM-1:0]  reqq_tgt_vld;
  logic [TGT_NUM*ENTRY_NUM-1:0]  reqq_tgt_aim;

  // Target handshakes
  logic [TGT_NUM-1:0]            tgt_req_vld;
  logic [TGT_NUM*ENTRY_W-1:0]    tgt_req_id;
  logic [TGT_NUM-1:0]            tgt_req_rdy;
  logic [TGT_NUM*ENTRY_NUM-1:0]  reqq_pop_en;

  // Response completion
  logic                          resp_done_vld;
  logic [ENTRY_W-1:0]            resp_done_id;
  logic [ENTRY_NUM-1:0]          reqq_resp_done;

  modport master (
    input  ctc_dvm_vld, reqq_vld, reqq_tgt_vld, reqq_tgt_aim,
           tgt_req_rdy, resp_done_vld, resp_done_id,
    output ctc_dvm_grant, reqq_create_en, reqq_full,
           tgt_req_vld, tgt_req_id, reqq_pop_en, reqq_resp_done
  );

  modport slave (
    output ctc_dvm_vld, reqq_vld, reqq_tgt_vld, reqq_tgt_aim,
           tgt_req_rdy, resp_done_vld, resp_done_id,
    input  ctc_dvm_grant, reqq_create_en, reqq_full,
           tgt_req_vld, tgt_req_id, reqq_pop_en, reqq_resp_done
  );

endinterface

// File: rtl/ct_ciu_ctcq_tgt_ptr.sv
// Per-target read pointer: walks entries in allocation order, skipping
// entries not aimed at this target and handshaking the ones that are.
module ct_ciu_ctcq_tgt_ptr #(
  parameter int unsigned ENTRY_NUM = 8,
  parameter int unsigned ENTRY_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ENTRY_NUM-1:0] ent_pend,
  input  logic [ENTRY_NUM-1:0] ent_aim,
  input  logic                 req_rdy,
  output logic                 req_vld,
  output logic [ENTRY_W-1:0]   req_id,
  output logic [ENTRY_NUM-1:0] pop_en
);

  logic [ENTRY_W-1:0] rd_ptr_q;
  logic [ENTRY_W-1:0] rd_ptr_d;
  logic               pend;
  logic               aim;
  logic               adv;

  // Skip or request decision for the entry under the read pointer.
  always_comb begin
    pend     = ent_pend[rd_ptr_q];
    aim      = ent_aim[rd_ptr_q];
    req_vld  = pend & aim;
    req_id   = rd_ptr_q;
    // A pending entry leaves this target either by skip or by accepted request.
    adv      = pend & (~aim | req_rdy);
    pop_en   = '0;
    if (adv) begin
      pop_en[rd_ptr_q] = 1'b1;
    end
    // Power-of-two depth: natural overflow wraps ENTRY_NUM-1 to 0.
    rd_ptr_d = adv ? rd_ptr_q + ENTRY_W'(1) : rd_ptr_q;
  end

  // Read pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/ct_ciu_ctcq_reqq_sched.sv
// CTC/DVM request queue scheduler: circular allocation, per-target in-order
// delivery and response-done decode for the reqq entry array.
module ct_ciu_ctcq_reqq_sched
  import ct_ciu_ctcq_pkg::*;
#(
  parameter int unsigned ENTRY_NUM = 8,
  parameter int unsigned ENTRY_W   = 3
) (
  input  logic                       forever_cpuclk,
  input  logic                       cpurst,
  ct_ciu_ctcq_reqq_sched_if.master   bus
);

  logic [ENTRY_W-1:0] tail_ptr_q;
  logic [ENTRY_W-1:0] tail_ptr_d;
  logic               grant_c;

  // Allocation at the tail; a valid tail entry means every slot is in use.
  always_comb begin
    bus.reqq_full      = bus.reqq_vld[tail_ptr_q];
    grant_c            = bus.ctc_dvm_vld & ~bus.reqq_vld[tail_ptr_q];
    bus.ctc_dvm_grant  = grant_c;
    bus.reqq_create_en = '0;
    if (grant_c) begin
      bus.reqq_create_en[tail_ptr_q] = 1'b1;
    end
    tail_ptr_d = grant_c ? tail_ptr_q + ENTRY_W'(1) : tail_ptr_q;
  end

  // Tail pointer register.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      tail_ptr_q <= '0;
    end else begin
      tail_ptr_q <= tail_ptr_d;
    end
  end

  // Response-done routing: plain decode, entry validity is the entry's concern.
  always_comb begin
    bus.reqq_resp_done = '0;
    if (bus.resp_done_vld) begin
      bus.reqq_resp_done[bus.resp_done_id] = 1'b1;
    end
  end

  // One read pointer per target, each on its own slice of the flat vectors.
  for (genvar t = 0; t < TGT_NUM; t++) begin : g_tgt
    localparam int unsigned BASE = tgt_vec_idx(t, 0, ENTRY_NUM);

    logic                 req_vld_w;
    logic [ENTRY_W-1:0]   req_id_w;
    logic [ENTRY_NUM-1:0] pop_w;

    ct_ciu_ctcq_tgt_ptr #(
      .ENTRY_NUM (ENTRY_NUM),
      .ENTRY_W   (ENTRY_W)
    ) u_tgt_ptr (
      .clk      (forever_cpuclk),
      .rst      (cpurst),
      .ent_pend (bus.reqq_tgt_vld[BASE +: ENTRY_NUM]),
      .ent_aim  (bus.reqq_tgt_aim[BASE +: ENTRY_NUM]),
      .req_rdy  (bus.tgt_req_rdy[t]),
      .req_vld  (req_vld_w),
      .req_id   (req_id_w),
      .pop_en   (pop_w)
    );

    assign bus.tgt_req_vld[t]                      = req_vld_w;
    assign bus.tgt_req_id[t*ENTRY_W +: ENTRY_W]    = req_id_w;
    assign bus.reqq_pop_en[BASE +: ENTRY_NUM]      = pop_w;
  end

endmodule

// File: tb/tb_ct_ciu_ctcq_reqq_sched.sv
// Scoreboard bench for the reqq scheduler with a behavioural entry array.
module tb_ct_ciu_ctcq_reqq_sched;
  import ct_ciu_ctcq_pkg::*;

  localparam int unsigned EN = 8;
  localparam int unsigned EW = 3;

  typedef struct {
    int e;
    bit req;
  } pop_exp_t;

  logic clk;
  logic cpurst;
  logic [TGT_NUM-1:0] cur_aim;

  int n_chk  = 0;
  int n_pass = 0;

  logic [EN-1:0] q_create[$];
  logic [EN-1:0] q_resp[$];
  pop_exp_t      q_pop[TGT_NUM][$];

  ct_ciu_ctcq_reqq_sched_if #(.ENTRY_NUM(EN), .ENTRY_W(EW)) ifc ();

  ct_ciu_ctcq_reqq_sched #(.ENTRY_NUM(EN), .ENTRY_W(EW)) dut (
    .forever_cpuclk (clk),
    .cpurst         (cpurst),
    .bus            (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Behavioural entry array: registered valid, per-target pending and aim.
  logic                m_vld  [EN];
  logic [TGT_NUM-1:0]  m_tgt  [EN];
  logic [TGT_NUM-1:0]  m_aim  [EN];
  logic                m_done [EN];

  for (genvar e = 0; e < EN; e++) begin : g_ent
    logic [TGT_NUM-1:0] pop_e;
    for (genvar t = 0; t < TGT_NUM; t++) begin : g_t
      assign pop_e[t]                  = ifc.reqq_pop_en[t*EN+e];
      assign ifc.reqq_tgt_vld[t*EN+e]  = m_tgt[e][t];
      assign ifc.reqq_tgt_aim[t*EN+e]  = m_aim[e][t];
    end
    assign ifc.reqq_vld[e] = m_vld[e];

    always @(posedge clk) begin
      if (cpurst) begin
        m_vld[e]  <= 1'b0;
        m_tgt[e]  <= '0;
        m_aim[e]  <= '0;
        m_done[e] <= 1'b0;
      end else if (ifc.reqq_create_en[e]) begin
        m_vld[e]  <= 1'b1;
        m_tgt[e]  <= '1;
        m_aim[e]  <= cur_aim;
        m_done[e] <= 1'b0;
      end else begin
        m_tgt[e]  <= m_tgt[e] & ~pop_e;
        m_done[e] <= m_done[e] | ifc.reqq_resp_done[e];
        if (m_vld[e] && ((m_tgt[e] & ~pop_e) == '0) && (m_done[e] || ifc.reqq_resp_done[e]))
          m_vld[e] <= 1'b0;
      end
    end
  end

  // Allocation monitor.
  always @(negedge clk) begin
    if (!cpurst) begin
      if (ifc.ctc_dvm_grant) begin
        if (q_create.size() == 0) chk("create_unexpected", 64'(ifc.reqq_create_en), 64'd0);
        else chk("create_en", 64'(ifc.reqq_create_en), 64'(q_create.pop_front()));
      end else if (ifc.reqq_create_en != '0) begin
        chk("create_without_grant", 64'(ifc.reqq_create_en), 64'd0);
      end
    end
  end

  // Response-done monitor.
  always @(negedge clk) begin
    if (!cpurst && ifc.reqq_resp_done != '0) begin
      if (q_resp.size() == 0) chk("resp_unexpected", 64'(ifc.reqq_resp_done), 64'd0);
      else chk("resp_done", 64'(ifc.reqq_resp_done), 64'(q_resp.pop_front()));
    end
  end

  // Per-target pop monitors: order, skip-vs-request and presented id.
  for (genvar t = 0; t < TGT_NUM; t++) begin : g_mon
    logic [EN-1:0] pop_t;
    logic [EW-1:0] id_t;
    assign pop_t = ifc.reqq_pop_en[t*EN +: EN];
    assign id_t  = ifc.tgt_req_id[t*EW +: EW];

    always @(negedge clk) begin : mon
      pop_exp_t x;
      if (!cpurst && pop_t != '0) begin
        if (q_pop[t].size() == 0) begin
          chk($sformatf("pop_unexpected_t%0d", t), 64'(pop_t), 64'd0);
        end else begin
          x = q_pop[t].pop_front();
          chk($sformatf("pop_entry_t%0d", t), 64'(pop_t), 64'd1 << x.e);
          chk($sformatf("pop_req_vld_t%0d", t), 64'(ifc.tgt_req_vld[t]), 64'(x.req));
          if (x.req) chk($sformatf("pop_req_id_t%0d", t), 64'(id_t), 64'(x.e));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_create(input int e, input logic [TGT_NUM-1:0] aim);
    logic [EN-1:0] oh;
    pop_exp_t x;
    oh = '0;
    oh[EW'(e)] = 1'b1;
    q_create.push_back(oh);
    cur_aim = aim;
    ifc.ctc_dvm_vld = 1'b1;
    for (int t = 0; t < TGT_NUM; t++) begin
      x.e   = e;
      x.req = aim[3'(t)];
      q_pop[3'(t)].push_back(x);
    end
  endtask

  task automatic issue_resp(input int e);
    logic [EN-1:0] oh;
    oh = '0;
    oh[EW'(e)] = 1'b1;
    q_resp.push_back(oh);
    ifc.resp_done_vld = 1'b1;
    ifc.resp_done_id  = EW'(e);
  endtask

  function automatic int sb_pending();
    int n;
    n = q_create.size() + q_resp.size();
    for (int t = 0; t < TGT_NUM; t++) n += q_pop[3'(t)].size();
    return n;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_grant"},   64'(ifc.ctc_dvm_grant),  64'd0);
    chk({tag, "_create"},  64'(ifc.reqq_create_en), 64'd0);
    chk({tag, "_full"},    64'(ifc.reqq_full),      64'd0);
    chk({tag, "_req_vld"}, 64'(ifc.tgt_req_vld),    64'd0);
    chk({tag, "_req_id"},  64'(ifc.tgt_req_id),     64'd0);
    chk({tag, "_pop"},     64'(ifc.reqq_pop_en),    64'd0);
    chk({tag, "_resp"},    64'(ifc.reqq_resp_done), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1);
  end

  initial begin
    cpurst            = 1'b1;
    cur_aim           = '0;
    ifc.ctc_dvm_vld   = 1'b0;
    ifc.tgt_req_rdy   = '0;
    ifc.resp_done_vld = 1'b0;
    ifc.resp_done_id  = '0;

    // Reset state.
    repeat (2) cyc();
    #2;
    chk_idle("in_reset");
    cpurst = 1'b0;
    cyc();
    #2;
    chk_idle("post_reset");

    // Fill all eight entries with targets stalled; ninth cycle sees full.
    cyc();
    for (int i = 0; i < 8; i++) begin
      issue_create(i, 6'h3f);
      cyc();
    end
    #2;
    chk("full_9th",        64'(ifc.reqq_full),      64'd1);
    chk("grant_9th",       64'(ifc.ctc_dvm_grant),  64'd0);
    chk("create_9th",      64'(ifc.reqq_create_en), 64'd0);
    chk("stall_req_vld",   64'(ifc.tgt_req_vld),    64'h3f);
    chk("stall_req_id",    64'(ifc.tgt_req_id),     64'd0);
    ifc.ctc_dvm_vld = 1'b0;

    // Drain: each target pops one entry per cycle, then retire via responses.
    ifc.tgt_req_rdy = '1;
    repeat (8) cyc();
    #2;
    chk("drained_req_vld", 64'(ifc.tgt_req_vld),  64'd0);
    chk("drained_pop",     64'(ifc.reqq_pop_en),  64'd0);
    for (int i = 0; i < 8; i++) begin
      issue_resp(i);
      cyc();
    end
    ifc.resp_done_vld = 1'b0;
    cyc();
    #2;
    chk("retired_full",    64'(ifc.reqq_full),    64'd0);

    // Wrapped pointers: entry 0 aimed at PIU0 and L2C only.
    cyc();
    issue_create(0, 6'b100001);
    #2;
    chk("wrap_not_visible_vld", 64'(ifc.tgt_req_vld), 64'd0);
    chk("wrap_not_visible_pop", 64'(ifc.reqq_pop_en), 64'd0);
    cyc();
    issue_create(1, 6'h3f);
    #2;
    chk("aim_req_vld",  64'(ifc.tgt_req_vld),  64'b100001);
    chk("aim_req_id",   64'(ifc.tgt_req_id),   64'd0);
    chk("aim_pop_all",  64'(ifc.reqq_pop_en),  64'h0101_0101_0101);
    cyc();
    issue_create(2, 6'h3f);
    cyc();
    ifc.ctc_dvm_vld = 1'b0;
    repeat (3) cyc();
    for (int i = 0; i < 3; i++) begin
      issue_resp(i);
      cyc();
    end
    ifc.resp_done_vld = 1'b0;

    // Move tail and read pointers to 5, then reset mid-operation.
    issue_create(3, 6'h3f);
    cyc();
    issue_create(4, 6'h3f);
    cyc();
    ifc.ctc_dvm_vld = 1'b0;
    repeat (3) cyc();
    #2;
    chk("pre_rst_full",    64'(ifc.reqq_full),    64'd0);
    chk("pre_rst_sb",      64'(sb_pending()),     64'd0);
    cpurst = 1'b1;
    cyc();
    cpurst = 1'b0;

    // After reset: pointers at 0, create lands on entry 0; PIU2 stalls.
    ifc.tgt_req_rdy = 6'b111011;
    issue_create(0, 6'b000100);
    #2;
    chk("rst_req_vld",  64'(ifc.tgt_req_vld),    64'd0);
    chk("rst_req_id",   64'(ifc.tgt_req_id),     64'd0);
    chk("rst_pop",      64'(ifc.reqq_pop_en),    64'd0);
    chk("rst_create",   64'(ifc.reqq_create_en), 64'h01);
    chk("rst_grant",    64'(ifc.ctc_dvm_grant),  64'd1);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k < 3) issue_create(k, 6'b000100);
      else ifc.ctc_dvm_vld = 1'b0;
      #2;
      chk($sformatf("piu2_stall_vld_c%0d", k), 64'(ifc.tgt_req_vld[TGT_PIU2]), 64'd1);
      chk($sformatf("piu2_stall_id_c%0d", k),  64'(ifc.tgt_req_id[TGT_PIU2*EW +: EW]), 64'd0);
      chk($sformatf("piu2_stall_pop_c%0d", k), 64'(ifc.reqq_pop_en[TGT_PIU2*EN +: EN]), 64'd0);
    end
    cyc();
    ifc.tgt_req_rdy = '1;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("piu2_pop_seq%0d", k), 64'(ifc.reqq_pop_en[TGT_PIU2*EN +: EN]), 64'd1 << k);
      cyc();
    end
    #2;
    chk("piu2_done_vld", 64'(ifc.tgt_req_vld), 64'd0);

    // Response decode for one cycle, then suppressed by vld = 0.
    cyc();
    issue_resp(5);
    #2;
    chk("resp_id5_vld1", 64'(ifc.reqq_resp_done), 64'h20);
    cyc();
    ifc.resp_done_vld = 1'b0;
    #2;
    chk("resp_id5_vld0", 64'(ifc.reqq_resp_done), 64'h00);

    repeat (3) cyc();
    chk("sb_drained", 64'(sb_pending()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ct_ciu_ctcq_reqq_sched.md
Name: ct_ciu_ctcq_reqq_sched

Overview:
- Scheduler for the CTC/DVM request queue (reqq) entry array inside the CIU.
- Allocates entries in circular order for incoming DVM/CTC requests.
- Sequences each entry's delivery to six targets (PIU0-3, EBIU, L2C) in strict allocation order per target.
- Routes response-done indications back to entries; entries self-retire once all targets are popped and the response is done.

Parameters:
- ENTRY_NUM, 8, number of reqq entries (power of 2, 2..16).
- ENTRY_W, 3, log2(ENTRY_NUM).
- TGT_NUM, 6, targets; index 0-3 = PIU0-3, 4 = EBIU, 5 = L2C (matches entry aim bit order).

Ports:
- forever_cpuclk  in  1  clock.
- cpurst  in  1  synchronous active-high reset.
- ctc_dvm_vld  in  1  new request offered.
- ctc_dvm_grant  out  1  request accepted this cycle (= ctc_dvm_vld & !reqq_full).
- reqq_create_en  out  ENTRY_NUM  one-hot create strobe to entries.
- reqq_full  out  1  entry at tail pointer is valid.
- reqq_vld  in  ENTRY_NUM  entry valid (reqq_vld_x of each entry).
- reqq_tgt_vld  in  TGT_NUM*ENTRY_NUM  per-target pending, entry-major within target: [t*ENTRY_NUM+e].
- reqq_tgt_aim  in  TGT_NUM*ENTRY_NUM  per-target aim bit, same layout.
- tgt_req_vld  out  TGT_NUM  request to target t.
- tgt_req_id  out  TGT_NUM*ENTRY_W  entry index presented to target t; drives the address/mid mux outside.
- tgt_req_rdy  in  TGT_NUM  target t accepts.
- reqq_pop_en  out  TGT_NUM*ENTRY_NUM  one-hot pop per target; feeds reqq_pop0..3/pop_ebiu/popl2c_en_x.
- resp_done_vld  in  1  response completed.
- resp_done_id  in  ENTRY_W  entry of completed response.
- reqq_resp_done  out  ENTRY_NUM  one-hot decode to reqq_resp_done_x.

Behaviour:
- State: tail_ptr[ENTRY_W-1:0] plus rd_ptr[t][ENTRY_W-1:0] per target. All reset to 0 on cpurst at the clock edge. No other state.
- Reset outputs: all outputs are combinational from state and inputs. During and after reset, with reqq_vld == 0, every output is 0 except tgt_req_id = 0.
- Allocation:
  - reqq_full = reqq_vld[tail_ptr].
  - On ctc_dvm_vld & !reqq_full: reqq_create_en = one-hot(tail_ptr), ctc_dvm_grant = 1, tail_ptr increments mod ENTRY_NUM at the next edge.
  - When full: grant = 0 and create_en = 0; the request holds upstream.
- Per target t, with e = rd_ptr[t] and pend = reqq_tgt_vld[t][e]:
  - pend & !aim[t][e] (skip): reqq_pop_en[t][e] = 1 combinationally, tgt_req_vld[t] = 0, rd_ptr[t]++ next edge. One skip per target per cycle.
  - pend & aim[t][e]: tgt_req_vld[t] = 1, tgt_req_id[t] = e.
    - If tgt_req_rdy[t] is also 1: pop_en[t][e] = 1 and rd_ptr[t]++.
    - Otherwise request and id stay stable until rdy.
  - !pend: no request, no pop, pointer holds. This covers an empty queue and waiting on a not-yet-created entry.
- Ordering invariant:
  - Each rd_ptr only advances on a pop of a valid entry.
  - Entries retire only after all six target flags clear, so no rd_ptr ever passes tail_ptr.
  - Entries therefore reach each target in allocation order.
- Latency:
  - An entry created at cycle N becomes visible to the targets at N+1, because entry vld is registered.
  - Minimum create-to-pop is 1 cycle.
  - A target with rdy tied to 1 pops one entry per cycle.
- Response: reqq_resp_done = resp_done_vld ? one-hot(resp_done_id) : 0. Pure decode, no check against reqq_vld.
- Simultaneous events:
  - Create and a target pop in the same cycle never hit the same entry, since create only targets a free entry. Both are legal.
  - All six targets may pop in the same cycle, on the same or different entries.
  - Wrap-around: tail_ptr and rd_ptr wrap from ENTRY_NUM-1 to 0 with no extra state.
- Reset mid-operation:
  - cpurst zeroes all pointers in the same edge.
  - Entries are reset in the same cycle by the shared reset tree.
  - In-flight target handshakes are dropped; targets must also be in reset.

Decomposition:
- Shared ct_ciu_ctcq_pkg holds:
  - target index constants TGT_PIU0..TGT_L2C;
  - TGT_NUM;
  - the entry-major vector index rule, as a function.
- One sub-module, ct_ciu_ctcq_tgt_ptr, instantiated TGT_NUM times. It owns one rd_ptr and contains the skip/req/pop logic for that target.
- Allocation and response decode stay in the top level.

Test Plan:
- Reset, then ctc_dvm_vld held for 8 cycles with all vld fed back from a behavioural entry model:
  - create_en = 0x01, 0x02, ... 0x80 on consecutive cycles;
  - 9th cycle: reqq_full = 1, grant = 0.
- Entry 0 with aim = 6'b100001, all rdy = 1:
  - cycle after create: PIU0 and L2C request id 0;
  - PIU1-3 and EBIU issue skip pops on entry 0 in the same cycle;
  - all six pop_en[t][0] are asserted together.
- PIU2 rdy = 0 for 5 cycles with entries 0-2 aimed at PIU2:
  - tgt_req_vld[2] = 1, tgt_req_id = 0 stable for 5 cycles;
  - after rdy, ids 0, 1, 2 are popped in consecutive cycles.
- Wrap: allocate 8 entries, retire all, allocate 3 more:
  - create_en = 0x01, 0x02, 0x04;
  - every rd_ptr wraps to 0 and requests id 0.
- resp_done_vld = 1, id = 5 -> reqq_resp_done = 0x20 for exactly that cycle; id = 5 with vld = 0 -> 0x00.
- cpurst asserted with tail_ptr = 5 and rd_ptrs non-zero -> next cycle all pointers are 0, tgt_req_vld = 0 and create_en targets entry 0.
